// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared types and constants for the multiply/divide unit:
//            operation encoding, FSM state encoding, iteration counts and
//            small helpers for operand decode and magnitude conversion.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int unsigned c_XLEN = 64;

    // Iterations per operation: one bit per cycle.
    localparam logic [6:0] c_ITERS_XLEN = 7'd64;
    localparam logic [6:0] c_ITERS_W    = 7'd32;

    typedef enum logic [3:0] {
        MDU_MUL    = 4'd0,
        MDU_MULH   = 4'd1,
        MDU_MULHSU = 4'd2,
        MDU_MULHU  = 4'd3,
        MDU_DIV    = 4'd4,
        MDU_DIVU   = 4'd5,
        MDU_REM    = 4'd6,
        MDU_REMU   = 4'd7,
        MDU_MULW   = 4'd8,
        MDU_DIVW   = 4'd9,
        MDU_DIVUW  = 4'd10,
        MDU_REMW   = 4'd11,
        MDU_REMUW  = 4'd12
    } mdu_op_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } mdu_state_t;

    typedef struct packed {
        logic isMul;
        logic isW;
        logic isRem;
        logic isHigh;
        logic aSigned;
        logic bSigned;
    } mdu_opinfo_t;

    function automatic mdu_opinfo_t decodeOp(mdu_op_t op);
        mdu_opinfo_t d;
        d = '0;
        case (op)
            MDU_MUL:    begin d.isMul = 1'b1; d.aSigned = 1'b1; d.bSigned = 1'b1; end
            MDU_MULH:   begin d.isMul = 1'b1; d.isHigh = 1'b1; d.aSigned = 1'b1; d.bSigned = 1'b1; end
            MDU_MULHSU: begin d.isMul = 1'b1; d.isHigh = 1'b1; d.aSigned = 1'b1; end
            MDU_MULHU:  begin d.isMul = 1'b1; d.isHigh = 1'b1; end
            MDU_DIV:    begin d.aSigned = 1'b1; d.bSigned = 1'b1; end
            MDU_DIVU:   begin end
            MDU_REM:    begin d.isRem = 1'b1; d.aSigned = 1'b1; d.bSigned = 1'b1; end
            MDU_REMU:   begin d.isRem = 1'b1; end
            MDU_MULW:   begin d.isMul = 1'b1; d.isW = 1'b1; d.aSigned = 1'b1; d.bSigned = 1'b1; end
            MDU_DIVW:   begin d.isW = 1'b1; d.aSigned = 1'b1; d.bSigned = 1'b1; end
            MDU_DIVUW:  begin d.isW = 1'b1; end
            MDU_REMW:   begin d.isW = 1'b1; d.isRem = 1'b1; d.aSigned = 1'b1; d.bSigned = 1'b1; end
            MDU_REMUW:  begin d.isW = 1'b1; d.isRem = 1'b1; end
            default:    begin end
        endcase
        return d;
    endfunction

    function automatic logic [63:0] sext32(logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // v is already zero-extended to 64 bits for W ops; the magnitude of a
    // negative W operand stays confined to the low 32 bits.
    function automatic logic [63:0] magnitude(logic [63:0] v, logic isW, logic neg);
        logic [63:0] n;
        n = ~v + 64'd1;
        if (!neg) return v;
        return isW ? {32'd0, n[31:0]} : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_signfix.sv
`default_nettype none
// ============================================================================
// Module   : mdu_signfix
// Purpose  : Combinational final-result formation: sign correction of the
//            unsigned magnitude result and W-form sign extension.
// Ports    : i_acc    - raw accumulator {remainder, quotient} or product
//            i_isMul  - multiply op (else divide/remainder)
//            i_isW    - 32-bit W form, sign-extend bit 31
//            i_isRem  - return remainder instead of quotient
//            i_isHigh - return high product half
//            i_negRes - negate product/quotient (operand signs differ)
//            i_negRem - negate remainder (dividend was negative)
//            o_result - final XLEN result
// Revision : 1.0 - initial release
// ============================================================================
module mdu_signfix
    import mdu_pkg::*;
(
    input  logic [127:0] i_acc,
    input  logic         i_isMul,
    input  logic         i_isW,
    input  logic         i_isRem,
    input  logic         i_isHigh,
    input  logic         i_negRes,
    input  logic         i_negRem,
    output logic [63:0]  o_result
);

    logic [127:0] w_prod;
    logic [63:0]  w_quo;
    logic [63:0]  w_rem;
    logic [63:0]  w_raw;

    assign w_prod = i_negRes ? (~i_acc + 128'd1) : i_acc;
    assign w_quo  = i_negRes ? (~i_acc[63:0] + 64'd1) : i_acc[63:0];
    assign w_rem  = i_negRem ? (~i_acc[127:64] + 64'd1) : i_acc[127:64];

    assign w_raw = i_isMul ? (i_isHigh ? w_prod[127:64] : w_prod[63:0])
                           : (i_isRem ? w_rem : w_quo);

    assign o_result = i_isW ? sext32(w_raw[31:0]) : w_raw;

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Purpose  : Iterative multiply/divide unit. Shift-add multiply and restoring
//            divide on operand magnitudes, one bit per cycle, followed by a
//            sign-correction cycle. Divide-by-zero and signed overflow are
//            resolved at accept time.
// Ports    : clk, reset (async active-low), valid_in/op/srca/srcb request,
//            flush abort, ready_out/busy handshake, valid_out/result output.
// Config   : MDU_EARLY_OUT_EN - multiply leaves MUL as soon as no multiplier
//            bits remain (divide latency unaffected).
// Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN = 64    // only 64 is supported
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  mdu_op_t         op,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic            flush,
    output logic            ready_out,
    output logic            busy,
    output logic            valid_out,
    output logic [XLEN-1:0] result
);

    mdu_state_t   r_state;
    mdu_state_t   w_nextState;
    mdu_state_t   w_mulStart;
    logic [6:0]   r_count;
    logic [127:0] r_acc;
    logic [127:0] r_mcand;
    logic [63:0]  r_mplier;
    logic [63:0]  r_res;
    logic         r_isMul;
    logic         r_isW;
    logic         r_isRem;
    logic         r_isHigh;
    logic         r_negRes;
    logic         r_negRem;

    // ---------------- request decode ----------------
    mdu_opinfo_t  w_info;
    logic         w_accept;
    logic         w_aNeg;
    logic         w_bNeg;
    logic [63:0]  w_aLow;
    logic [63:0]  w_bLow;
    logic [63:0]  w_aMag;
    logic [63:0]  w_bMag;
    logic         w_bZero;
    logic         w_ovf;
    logic         w_short;
    logic [63:0]  w_aExt;
    logic [63:0]  w_shortRes;

    assign w_info   = decodeOp(op);
    assign w_accept = (r_state == S_IDLE) && valid_in && !flush;

    assign w_aNeg = w_info.aSigned && (w_info.isW ? srca[31] : srca[63]);
    assign w_bNeg = w_info.bSigned && (w_info.isW ? srcb[31] : srcb[63]);
    assign w_aLow = w_info.isW ? {32'd0, srca[31:0]} : srca;
    assign w_bLow = w_info.isW ? {32'd0, srcb[31:0]} : srcb;
    assign w_aMag = magnitude(w_aLow, w_info.isW, w_aNeg);
    assign w_bMag = magnitude(w_bLow, w_info.isW, w_bNeg);

    assign w_bZero = (w_bLow == 64'd0);
    assign w_ovf   = w_info.aSigned &&
                     (w_info.isW ? (srca[31:0] == 32'h8000_0000 && srcb[31:0] == 32'hFFFF_FFFF)
                                 : (srca == 64'h8000_0000_0000_0000 && srcb == '1));
    assign w_short = !w_info.isMul && (w_bZero || w_ovf);

    // Dividend as seen by the program, W form sign-extended.
    assign w_aExt = w_info.isW ? sext32(srca[31:0]) : srca;

    // Divide by zero wins over overflow (overflow needs divisor -1 anyway).
    assign w_shortRes = w_bZero ? (w_info.isRem ? w_aExt : '1)
                                : (w_info.isRem ? 64'd0  : w_aExt);

    // ---------------- iteration datapath ----------------
    logic [127:0] w_mulAcc;
    logic [64:0]  w_divTop;
    logic         w_divGe;
    logic [63:0]  w_divDiff;
    logic [127:0] w_divAcc;
    logic         w_mulLast;
    logic [63:0]  w_fixRes;

    assign w_mulAcc = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Restoring step: r_acc = {remainder, quotient/dividend}, divisor in r_mcand.
    assign w_divTop  = r_acc[127:63];
    assign w_divGe   = (w_divTop >= {1'b0, r_mcand[63:0]});
    assign w_divDiff = w_divTop[63:0] - r_mcand[63:0];
    assign w_divAcc  = {(w_divGe ? w_divDiff : w_divTop[63:0]), r_acc[62:0], w_divGe};

`ifdef MDU_EARLY_OUT_EN
    // Stop once no multiplier bits remain beyond the one consumed this cycle;
    // a zero multiplier skips iterating altogether.
    assign w_mulLast  = (r_count == 7'd1) || (r_mplier[63:1] == 63'd0);
    assign w_mulStart = (w_bMag == 64'd0) ? S_FIX : S_MUL;
`else
    assign w_mulLast  = (r_count == 7'd1);
    assign w_mulStart = S_MUL;
`endif

    mdu_signfix u_signfix (
        .i_acc    (r_acc),
        .i_isMul  (r_isMul),
        .i_isW    (r_isW),
        .i_isRem  (r_isRem),
        .i_isHigh (r_isHigh),
        .i_negRes (r_negRes),
        .i_negRem (r_negRem),
        .o_result (w_fixRes)
    );

    // ---------------- FSM ----------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_info.isMul)  w_nextState = w_mulStart;
                    else if (w_short)  w_nextState = S_DONE;
                    else               w_nextState = S_DIV;
                end
            end
            S_MUL:   if (w_mulLast) w_nextState = S_FIX;
            S_DIV:   if (r_count == 7'd1) w_nextState = S_FIX;
            S_FIX:   w_nextState = S_DONE;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
        if (flush) w_nextState = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_count  <= 7'd0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_res    <= '0;
            r_isMul  <= 1'b0;
            r_isW    <= 1'b0;
            r_isRem  <= 1'b0;
            r_isHigh <= 1'b0;
            r_negRes <= 1'b0;
            r_negRem <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_isMul  <= w_info.isMul;
                        r_isW    <= w_info.isW;
                        r_isRem  <= w_info.isRem;
                        r_isHigh <= w_info.isHigh;
                        r_negRes <= w_aNeg ^ w_bNeg;
                        r_negRem <= w_aNeg;
                        r_count  <= w_info.isW ? c_ITERS_W : c_ITERS_XLEN;
                        r_mplier <= w_bMag;
                        r_res    <= w_shortRes;
                        if (w_info.isMul) begin
                            r_acc   <= '0;
                            r_mcand <= {64'd0, w_aMag};
                        end else begin
                            // W dividends are pre-aligned to the top so the
                            // 32 iterations consume exactly their bits.
                            r_acc   <= {64'd0, (w_info.isW ? (w_aMag << 32) : w_aMag)};
                            r_mcand <= {64'd0, w_bMag};
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_mulAcc;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count - 7'd1;
                end
                S_DIV: begin
                    r_acc   <= w_divAcc;
                    r_count <= r_count - 7'd1;
                end
                S_FIX:   r_res <= w_fixRes;
                default: begin end
            endcase
        end
    end

    assign ready_out = (r_state == S_IDLE);
    assign busy      = !ready_out;
    assign valid_out = (r_state == S_DONE) && !flush;
    assign result    = valid_out ? r_res : '0;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_ctrl
// Purpose  : Self-checking bench for mdu_ctrl: vector table of operations
//            with expected result and latency, plus flush, busy, and reset
//            sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        valid_in;
    mdu_op_t     op;
    logic [63:0] srca;
    logic [63:0] srcb;
    logic        flush;
    logic        ready_out;
    logic        busy;
    logic        valid_out;
    logic [63:0] result;

    mdu_ctrl #(.XLEN(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .op        (op),
        .srca      (srca),
        .srcb      (srcb),
        .flush     (flush),
        .ready_out (ready_out),
        .busy      (busy),
        .valid_out (valid_out),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        mdu_op_t     op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
        string       name;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   nPass;
    int   nTotal;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nTotal++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%016h, expected 0x%016h", name, got, exp);
    endtask

    // Expected latency of a table entry in this build.
    function automatic int expLat(input mdu_op_t o, input logic [63:0] b, input int lat);
`ifdef MDU_EARLY_OUT_EN
        logic [63:0] m;
        logic [31:0] m32;
        int          k;
        if (!(o inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU, MDU_MULW})) return lat;
        m = (o == MDU_MULW) ? {32'd0, b[31:0]} : b;
        if ((o == MDU_MUL || o == MDU_MULH) && b[63]) m = ~b + 64'd1;
        if (o == MDU_MULW && b[31]) begin
            m32 = ~b[31:0] + 32'd1;
            m   = {32'd0, m32};
        end
        k = 0;
        for (int i = 0; i < 64; i++) if (m[i]) k = i + 1;
        return k + 2;
`else
        if (o == MDU_MULW && b === 64'hx) return 0;
        return lat;
`endif
    endfunction

    // Drive one request, push its expectation, wait for the strobe and compare.
    // hold > 0 keeps valid_in high (with other operands) while busy.
    task automatic runOp(input mdu_op_t o, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] expRes, input int lat, input string name,
                         input int hold);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clk);
        op = o; srca = a; srcb = b; valid_in = 1'b1;
        e.res = expRes; e.lat = expLat(o, b, lat);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (hold == 0) valid_in = 1'b0;
        else begin op = MDU_MULHU; srca = 64'h1234; srcb = 64'h5678; end
        n = 0; seen = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (valid_out) seen = 1;
            if (n == hold) valid_in = 1'b0;
        end
        valid_in = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            check({name, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check({name, "_result"}, result, e.res);
            check({name, "_latency"}, 64'(n), 64'(e.lat));
            @(negedge clk);
            check({name, "_strobe_one_cycle"}, {63'd0, valid_out}, 64'd0);
            check({name, "_result_zero_after"}, result, 64'd0);
        end
    endtask

    task automatic countStrobes(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (valid_out) n++;
        end
    endtask

    task automatic checkIdleOutputs(input string name);
        check({name, "_ready"}, {63'd0, ready_out}, 64'd1);
        check({name, "_busy"}, {63'd0, busy}, 64'd0);
        check({name, "_valid"}, {63'd0, valid_out}, 64'd0);
        check({name, "_result"}, result, 64'd0);
    endtask

    initial begin
        int nStrobe;
        nPass = 0; nTotal = 0;
        reset = 1'b0; valid_in = 1'b0; flush = 1'b0;
        op = MDU_MUL; srca = '0; srcb = '0;

        vecs.push_back('{MDU_MUL,    64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 66, "mul_7_m3"});
        vecs.push_back('{MDU_DIV,    64'hFFFFFFFFFFFFFFEC, 64'd6, 64'hFFFFFFFFFFFFFFFD, 66, "div_m20_6"});
        vecs.push_back('{MDU_REM,    64'hFFFFFFFFFFFFFFEC, 64'd6, 64'hFFFFFFFFFFFFFFFE, 66, "rem_m20_6"});
        vecs.push_back('{MDU_DIVU,   64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1, "divu_by0"});
        vecs.push_back('{MDU_REMU,   64'd5, 64'd0, 64'd5, 1, "remu_by0"});
        vecs.push_back('{MDU_DIV,    64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1, "div_ovf"});
        vecs.push_back('{MDU_REM,    64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1, "rem_ovf"});
        vecs.push_back('{MDU_DIVW,   64'h0000000080000000, 64'h00000000FFFFFFFF, 64'hFFFFFFFF80000000, 1, "divw_ovf"});
        vecs.push_back('{MDU_MULW,   64'h000000007FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, 34, "mulw_7fff_2"});
        vecs.push_back('{MDU_MULHU,  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 66, "mulhu_max"});
        vecs.push_back('{MDU_MULH,   64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000, 66, "mulh_min_min"});
        vecs.push_back('{MDU_MULHSU, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 66, "mulhsu_m1_max"});
        vecs.push_back('{MDU_MUL,    64'h0000000100000001, 64'h0000000100000001, 64'h0000000200000001, 66, "mul_wide"});
        vecs.push_back('{MDU_DIVU,   64'd100, 64'd7, 64'd14, 66, "divu_100_7"});
        vecs.push_back('{MDU_REMU,   64'd100, 64'd7, 64'd2, 66, "remu_100_7"});
        vecs.push_back('{MDU_REM,    64'd20, 64'hFFFFFFFFFFFFFFFA, 64'd2, 66, "rem_20_m6"});
        vecs.push_back('{MDU_DIVUW,  64'hFFFFFFFFFFFFFFF0, 64'd16, 64'h000000000FFFFFFF, 34, "divuw"});
        vecs.push_back('{MDU_REMW,   64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 34, "remw_m7_2"});
        vecs.push_back('{MDU_REMUW,  64'h0000000123456789, 64'hFFFFFFFF00000000, 64'h0000000023456789, 1, "remuw_by0"});
        vecs.push_back('{MDU_DIVW,   64'h12345678FFFFFFEC, 64'd6, 64'hFFFFFFFFFFFFFFFD, 34, "divw_m20_6"});
        vecs.push_back('{MDU_DIVW,   64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1, "divw_by0"});
        vecs.push_back('{MDU_REMW,   64'h0000000080000000, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1, "remw_ovf"});
        vecs.push_back('{MDU_MULW,   64'h0000000080000000, 64'h00000000FFFFFFFF, 64'hFFFFFFFF80000000, 34, "mulw_min_m1"});

        // Reset state
        #1;
        checkIdleOutputs("reset_hold");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkIdleOutputs("after_reset");

        foreach (vecs[i])
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name, 0);

        // valid_in held high while busy must be ignored
        runOp(MDU_DIVU, 64'd100, 64'd7, 64'd14, 66, "busy_ignore", 5);

        // Flush 10 cycles after accepting a divide
        @(negedge clk);
        op = MDU_DIV; srca = 64'd1000; srcb = 64'd3; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_div_ready", {63'd0, ready_out}, 64'd1);
        check("flush_div_busy", {63'd0, busy}, 64'd0);
        countStrobes(80, nStrobe);
        check("flush_div_no_strobe", 64'(nStrobe), 64'd0);
        runOp(MDU_MUL, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 66, "mul_after_flush", 0);

        // Flush wins over a simultaneous accept
        @(negedge clk);
        op = MDU_DIVU; srca = 64'd5; srcb = 64'd0; valid_in = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_prio_ready", {63'd0, ready_out}, 64'd1);
        check("flush_prio_valid", {63'd0, valid_out}, 64'd0);

        // Flush during the DONE cycle suppresses the strobe
        @(negedge clk);
        op = MDU_DIVU; srca = 64'd5; srcb = 64'd0; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0; flush = 1'b1;
        #1;
        check("flush_done_busy", {63'd0, busy}, 64'd1);
        check("flush_done_valid", {63'd0, valid_out}, 64'd0);
        check("flush_done_result", result, 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_done_ready", {63'd0, ready_out}, 64'd1);
        check("flush_done_valid_after", {63'd0, valid_out}, 64'd0);

        // Reset pulse mid-MULH abandons the operation
        @(negedge clk);
        op = MDU_MULH; srca = 64'd12345; srcb = 64'd678; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        checkIdleOutputs("reset_mid_op");
        @(negedge clk);
        reset = 1'b1;
        countStrobes(80, nStrobe);
        check("reset_mid_op_no_strobe", 64'(nStrobe), 64'd0);

`ifdef MDU_EARLY_OUT_EN
        runOp(MDU_MUL, 64'd5, 64'd0, 64'd0, 2, "early_out_zero", 0);
`endif
        runOp(MDU_MUL, 64'd3, 64'd5, 64'd15, 66, "mul_final", 0);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand/result width; only 64 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port valid_in  input  1  request from execute stage.
REQ-005 SHALL have port op  input  mdu_op_t  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW.
REQ-006 SHALL have port srca  input  XLEN  rs1 value.
REQ-007 SHALL have port srcb  input  XLEN  rs2 value.
REQ-008 SHALL have port flush  input  1  abort in-flight operation.
REQ-009 SHALL have port ready_out  output  1  high only in IDLE.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE; drives the pipeline stall.
REQ-011 SHALL have port valid_out  output  1  one-cycle result strobe.
REQ-012 SHALL have port result  output  XLEN  final value; valid only while valid_out is high.

Function
REQ-013 SHALL accept an operation on a rising edge where valid_in and ready_out are high and flush is low, latching op, srca and srcb.
REQ-014 SHALL implement states IDLE, MUL, DIV, FIX and DONE.
REQ-015 SHALL transition IDLE->MUL on a multiply op, IDLE->DIV on a divide/remainder op, and IDLE->DONE on a short-circuit case.
REQ-016 SHALL, in MUL and DIV, iterate one bit per cycle (shift-add / restoring) with an iteration counter that runs 64 iterations, or 32 for W ops.
REQ-017 SHALL move to FIX when the counter expires, then to DONE, then to IDLE.
REQ-018 SHALL, in FIX, apply sign correction from the latched operand signs: negate the product or quotient when the signs differ, and give the remainder the dividend's sign.
REQ-019 SHALL produce valid_out XLEN+2 cycles after the accept edge for full ops (66 cycles, or 34 for W ops), and 1 cycle after for short-circuit cases.
REQ-020 SHALL hold valid_out high for exactly one cycle (the DONE state).
REQ-021 SHALL return the low product half for MUL and MULW, and the high half for MULH, MULHSU and MULHU (MULHSU: srca signed, srcb unsigned).
REQ-022 SHALL, for W ops, use srca[31:0] and srcb[31:0] and sign-extend bit 31 of the 32-bit result to XLEN.
REQ-023 SHALL short-circuit division by zero: quotient all ones, remainder equal to the dividend; for W ops these values are sign-extended from 32 bits.
REQ-024 SHALL short-circuit signed overflow (most-negative value / -1, for both XLEN and W): quotient equal to the dividend, remainder 0.
REQ-025 SHALL ignore valid_in while busy is high.
REQ-026 SHALL, when flush is high, enter IDLE on the next edge from any state, suppress valid_out, and discard partial results.
REQ-027 SHALL give flush priority over a simultaneous accept.
REQ-028 SHALL, when flush coincides with the DONE cycle, suppress valid_out.
REQ-029 SHALL drive result to 0 whenever valid_out is low.

Reset
REQ-030 SHALL, on reset low, asynchronously enter IDLE and clear the counter and all operand and accumulator registers.
REQ-031 SHALL hold ready_out=1, busy=0, valid_out=0 and result=0 while reset is low.
REQ-032 SHALL, on reset asserted mid-operation, abandon the operation with no valid_out after release.

Configuration
REQ-033 SHALL compile multiply early-out logic only when MDU_EARLY_OUT_EN is defined.
REQ-034 SHALL, with MDU_EARLY_OUT_EN defined, leave MUL for FIX as soon as the remaining multiplier register is zero, checked every MUL cycle including the first.
REQ-035 SHALL, with MDU_EARLY_OUT_EN defined, have latency k+2, where k is the number of iterations executed; a zero multiplier gives latency 2.
REQ-036 SHALL, without MDU_EARLY_OUT_EN, have fixed latency per REQ-019; divide latency is never affected by the macro.

Structure
REQ-037 SHALL place mdu_op_t, the state enum and the iteration-count constants (64, 32) in shared package mdu_pkg, imported alongside common.
REQ-038 SHALL place the combinational sign correction and W-form sign extension in sub-module mdu_signfix, instantiated once.

Verification
REQ-039 SHALL verify MUL srca=7, srcb=-3 -> valid_out at accept+66, result=0xFFFFFFFFFFFFFFEB.
REQ-040 SHALL verify DIV srca=-20, srcb=6 -> result=0xFFFFFFFFFFFFFFFD; REM of the same operands -> result=0xFFFFFFFFFFFFFFFE.
REQ-041 SHALL verify DIVU srcb=0, srca=5 -> valid_out at accept+1, result all ones; REMU srcb=0, srca=5 -> result 5; DIV 0x8000000000000000 / -1 -> result 0x8000000000000000.
REQ-042 SHALL verify DIVW srca=0x80000000, srcb=0xFFFFFFFF -> result 0xFFFFFFFF80000000 at accept+1; MULW 0x7FFFFFFF*2 -> result 0xFFFFFFFFFFFFFFFE at accept+34.
REQ-043 SHALL verify flush asserted 10 cycles after accepting DIV -> IDLE next cycle, no valid_out; a new MUL accepted next -> correct result.
REQ-044 SHALL verify reset pulsed low mid-MULH -> no valid_out after release; and, with MDU_EARLY_OUT_EN, MUL srcb=0 -> valid_out at accept+2, result 0.
